// File: rtl/mole_field_ctrl.sv
// Whack-a-mole play field: raises moles from the sequence generator's ctrl vector,
// times them, scores whacks and runs the round clock. WHACK_PENALTY_EN charges false whacks.
module mole_field_ctrl #(
  parameter int N_MOLES    = 8,
  parameter int UP_TICKS   = 3,
  parameter int GAME_TICKS = 60,
  parameter int CNT_W      = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [N_MOLES-1:0] ctrl,
  input  logic [N_MOLES-1:0] hit,
  output logic [N_MOLES-1:0] mole_up,
  output logic [CNT_W-1:0]   score,
  output logic [CNT_W-1:0]   miss,
  output logic [7:0]         time_left,
  output logic               playing,
  output logic               game_over,
  output logic               seq_shift
);

  localparam int PC_W  = $clog2(N_MOLES + 1);
  localparam int SUM_W = CNT_W + PC_W + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t                    state;
  logic [N_MOLES-1:0]        hit_q, hit_edge, scored, expired, up_nxt;
  logic [N_MOLES-1:0][3:0]   timer, timer_nxt;
  logic [PC_W-1:0]           n_scored, n_expired;
  logic [SUM_W-1:0]          score_sum, miss_sum;
  logic [CNT_W-1:0]          score_nxt, miss_nxt;
`ifdef WHACK_PENALTY_EN
  logic [N_MOLES-1:0]        false_whack;
  logic [PC_W-1:0]           n_false;
`endif

  function automatic logic [PC_W-1:0] popcount(input logic [N_MOLES-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_MOLES; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  // Per-mole priority: whack, then tick ageing/expiry, then raise on a down mole.
  always_comb begin
    hit_edge  = hit & ~hit_q;
    scored    = '0;
    expired   = '0;
    up_nxt    = mole_up;
    timer_nxt = timer;
    for (int i = 0; i < N_MOLES; i++) begin
      if (hit_edge[i] && mole_up[i]) begin
        scored[i]    = 1'b1;
        up_nxt[i]    = 1'b0;
        timer_nxt[i] = '0;
      end else if (tick && mole_up[i]) begin
        if (timer[i] == 4'd1) begin
          expired[i]   = 1'b1;
          up_nxt[i]    = 1'b0;
          timer_nxt[i] = '0;
        end else begin
          timer_nxt[i] = timer[i] - 4'd1;
        end
      end else if (tick && ctrl[i]) begin
        up_nxt[i]    = 1'b1;
        timer_nxt[i] = 4'(UP_TICKS);
      end
    end
  end

  always_comb begin
    n_scored  = popcount(scored);
    n_expired = popcount(expired);
    score_sum = SUM_W'(score) + SUM_W'(n_scored);
`ifdef WHACK_PENALTY_EN
    false_whack = hit_edge & ~mole_up;
    n_false     = popcount(false_whack);
    if (score_sum < SUM_W'(n_false)) score_sum = '0;
    else                             score_sum = score_sum - SUM_W'(n_false);
`endif
    miss_sum  = SUM_W'(miss) + SUM_W'(n_expired);
    score_nxt = (score_sum > CNT_MAX) ? {CNT_W{1'b1}} : score_sum[CNT_W-1:0];
    miss_nxt  = (miss_sum > CNT_MAX) ? {CNT_W{1'b1}} : miss_sum[CNT_W-1:0];
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hit_q     <= '0;
      mole_up   <= '0;
      timer     <= '0;
      score     <= '0;
      miss      <= '0;
      time_left <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      seq_shift <= 1'b0;
    end else begin
      hit_q     <= hit;
      seq_shift <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= PLAY;
            playing   <= 1'b1;
            game_over <= 1'b0;
            time_left <= 8'(GAME_TICKS);
            score     <= '0;
            miss      <= '0;
            mole_up   <= '0;
            timer     <= '0;
          end
        end
        PLAY: begin
          score <= score_nxt;
          if (tick) seq_shift <= 1'b1;
          // Final tick: moles still up are dropped without counting as misses.
          if (tick && time_left == 8'd1) begin
            state     <= OVER;
            playing   <= 1'b0;
            game_over <= 1'b1;
            time_left <= '0;
            mole_up   <= '0;
            timer     <= '0;
          end else begin
            miss    <= miss_nxt;
            mole_up <= up_nxt;
            timer   <= timer_nxt;
            if (tick) time_left <= time_left - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_field_ctrl.sv
// Randomized scoreboard bench for mole_field_ctrl against a tick-level game model.
module tb_mole_field_ctrl;

  localparam int NM  = 8;
  localparam int UP  = 3;
  localparam int GT  = 12;
  localparam int CW  = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0, start = 1'b0;
  logic [NM-1:0] ctrl = '0, hit = '0;
  logic [NM-1:0] mole_up;
  logic [CW-1:0] score, miss;
  logic [7:0]    time_left;
  logic          playing, game_over, seq_shift;

  mole_field_ctrl #(.N_MOLES(NM), .UP_TICKS(UP), .GAME_TICKS(GT), .CNT_W(CW)) dut (
    .CLOCK_50(clk), .reset(reset), .tick(tick), .start(start), .ctrl(ctrl), .hit(hit),
    .mole_up(mole_up), .score(score), .miss(miss), .time_left(time_left),
    .playing(playing), .game_over(game_over), .seq_shift(seq_shift));

  always #5 clk = ~clk;

  typedef struct {
    int up, sc, ms, tl, pl, ov, sh;
  } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;

  // Game model: phase 0 idle, 1 play, 2 over.
  int      m_phase = 0, m_sc = 0, m_ms = 0, m_tl = 0, m_sh = 0;
  bit [NM-1:0] m_up = '0, m_hq = '0;
  int      m_rem[NM];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit tk,
                            input bit [NM-1:0] ct, input bit [NM-1:0] ht);
    bit [NM-1:0] e, f;
    int nsc, nm, nf, s;
    if (rst) begin
      m_phase = 0; m_sc = 0; m_ms = 0; m_tl = 0; m_sh = 0; m_up = '0; m_hq = '0;
      foreach (m_rem[i]) m_rem[i] = 0;
      return;
    end
    e = ht & ~m_hq;
    m_hq = ht;
    m_sh = 0;
    if (m_phase != 1) begin
      if (st) begin
        m_phase = 1; m_tl = GT; m_sc = 0; m_ms = 0; m_up = '0;
      end
      return;
    end
    nsc = 0; nm = 0; nf = 0;
    f = e & ~m_up;
    for (int i = 0; i < NM; i++) begin
      if (f[i]) nf++;
      if (e[i] && m_up[i]) begin
        m_up[i] = 0; nsc++;
      end else if (tk && m_up[i]) begin
        if (m_rem[i] == 1) begin m_up[i] = 0; nm++; end
        else m_rem[i]--;
      end else if (tk && ct[i]) begin
        m_up[i] = 1; m_rem[i] = UP;
      end
    end
    s = m_sc + nsc;
`ifdef WHACK_PENALTY_EN
    s = (s - nf < 0) ? 0 : s - nf;
`endif
    m_sc = (s > MAXC) ? MAXC : s;
    if (tk) begin
      m_sh = 1;
      if (m_tl == 1) begin
        m_tl = 0; m_phase = 2; m_up = '0;
        return;
      end
      m_tl--;
    end
    m_ms = (m_ms + nm > MAXC) ? MAXC : m_ms + nm;
  endtask

  task automatic drive(input bit rst, input bit st, input bit tk,
                       input bit [NM-1:0] ct, input bit [NM-1:0] ht);
    exp_t x;
    @(negedge clk);
    reset = rst; start = st; tick = tk; ctrl = ct; hit = ht;
    model_step(rst, st, tk, ct, ht);
    x.up = int'(m_up); x.sc = m_sc; x.ms = m_ms; x.tl = m_tl;
    x.pl = (m_phase == 1) ? 1 : 0; x.ov = (m_phase == 2) ? 1 : 0; x.sh = m_sh;
    q.push_back(x);
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_mole_up", int'(mole_up), 0);
    chk("async_score", int'(score), 0);
    chk("async_miss", int'(miss), 0);
    chk("async_time_left", int'(time_left), 0);
    chk("async_playing", int'(playing), 0);
    chk("async_game_over", int'(game_over), 0);
    chk("async_seq_shift", int'(seq_shift), 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("mole_up", int'(mole_up), x.up);
        chk("score", int'(score), x.sc);
        chk("miss", int'(miss), x.ms);
        chk("time_left", int'(time_left), x.tl);
        chk("playing", int'(playing), x.pl);
        chk("game_over", int'(game_over), x.ov);
        chk("seq_shift", int'(seq_shift), x.sh);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bit [31:0]   r;
    bit [NM-1:0] ct, ht, hprev;
    bit          tk, st;
    hprev = '0;
    repeat (3) drive(1, 0, 0, '0, '0);
    // Start, raise mole 0, then let it age out with hit timing around expiry.
    drive(0, 1, 0, '0, '0);
    drive(0, 0, 1, 8'h01, '0);
    drive(0, 0, 0, '0, '0);
    drive(0, 0, 1, '0, '0);
    drive(0, 0, 1, '0, '0);
    drive(0, 0, 1, '0, 8'h01);
    drive(0, 0, 1, 8'h81, '0);
    repeat (3) drive(0, 0, 1, '0, '0);
    drive(0, 0, 0, '0, 8'h08);
    drive(0, 0, 0, '0, '0);
    for (int c = 0; c < 5000; c++) begin
      if (m_phase == 1 && $urandom_range(0, 399) == 0) begin
        async_reset();
        drive(1, 0, 0, '0, '0);
        hprev = '0;
        continue;
      end
      tk = ($urandom_range(0, 3) == 0);
      st = (m_phase != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      r  = $urandom;
      ct = r[NM-1:0];
      r  = $urandom;
      case ($urandom_range(0, 3))
        0: ht = '0;
        1: ht = m_up & r[NM-1:0];
        2: ht = r[NM-1:0];
        default: ht = hprev;
      endcase
      hprev = ht;
      drive(0, st, tk, ct, ht);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
